// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: per-sample controller for one equalizer band's serial FIR.
// For each accepted sample it strobes the delay-line shift, sweeps the tap
// index across every slot with the accumulator enabled, waits for the MAC
// pipeline to settle and then holds a result-valid handshake until taken.
// All outputs come straight from flops; next values are decoded from the
// next state so the registered outputs line up with the state they describe.

module fir_tap_sequencer #(
  parameter int NUM_TAPS    = 64,
  parameter int CNT_W       = 6,
  parameter int MAC_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             phase_0,
  output logic [CNT_W-1:0] current_count,
  output logic             acc_clear,
  output logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clear_overrun
);

  // Drain counter is sized for at least one bit so a zero-latency build
  // still elaborates; the DRAIN state is simply never entered then.
  localparam int LAT_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP   = CNT_W'(NUM_TAPS - 1);
  localparam logic [LAT_W-1:0] LAST_DRAIN = LAT_W'((MAC_LATENCY > 0) ? (MAC_LATENCY - 1) : 0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [LAT_W-1:0] drain_cnt_r;
  logic [LAT_W-1:0] drain_cnt_s;

  logic             sample_ready_s;
  logic             phase_0_s;
  logic [CNT_W-1:0] count_s;
  logic             acc_clear_s;
  logic             acc_en_s;
  logic             out_valid_s;
  logic             busy_s;
  logic             overrun_s;
  logic             overrun_set_s;

  // State and drain-cycle counter; reset lands in IDLE with the counter cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      drain_cnt_r <= {LAT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      drain_cnt_r <= drain_cnt_s;
    end
  end

  // Next-state decode; the sweep ends on the cycle that presents the last tap.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sample_valid && sample_ready) state_s = ST_SHIFT;
        else                              state_s = ST_IDLE;
      end
      ST_SHIFT: state_s = ST_MAC;
      ST_MAC: begin
        if (current_count == LAST_TAP) begin
          if (MAC_LATENCY == 0) state_s = ST_HOLD;
          else                  state_s = ST_DRAIN;
        end else begin
          state_s = ST_MAC;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == LAST_DRAIN) state_s = ST_HOLD;
        else                           state_s = ST_DRAIN;
      end
      ST_HOLD: begin
        if (out_ready) state_s = ST_IDLE;
        else           state_s = ST_HOLD;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Next output values, decoded from the state being entered.
  always_comb begin
    sample_ready_s = (state_s == ST_IDLE);
    busy_s         = (state_s != ST_IDLE);
    phase_0_s      = (state_s == ST_SHIFT);
    acc_en_s       = (state_s == ST_MAC);
    out_valid_s    = (state_s == ST_HOLD);

    // The tap index only advances while staying in MAC, so it starts at 0
    // on entry and never passes the last tap.
    if ((state_r == ST_MAC) && (state_s == ST_MAC)) count_s = current_count + {{(CNT_W-1){1'b0}}, 1'b1};
    else                                            count_s = {CNT_W{1'b0}};

    acc_clear_s = (state_s == ST_MAC) && (count_s == {CNT_W{1'b0}});

    if ((state_r == ST_DRAIN) && (state_s == ST_DRAIN)) drain_cnt_s = drain_cnt_r + {{(LAT_W-1){1'b0}}, 1'b1};
    else                                                drain_cnt_s = {LAT_W{1'b0}};

    // A sample offered while not ready is dropped; setting beats clearing.
    overrun_set_s = sample_valid && !sample_ready;
    if (overrun_set_s)      overrun_s = 1'b1;
    else if (clear_overrun) overrun_s = 1'b0;
    else                    overrun_s = overrun;
  end

  // Output registers; only sample_ready comes out of reset high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_ready  <= 1'b1;
      phase_0       <= 1'b0;
      current_count <= {CNT_W{1'b0}};
      acc_clear     <= 1'b0;
      acc_en        <= 1'b0;
      out_valid     <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      sample_ready  <= sample_ready_s;
      phase_0       <= phase_0_s;
      current_count <= count_s;
      acc_clear     <= acc_clear_s;
      acc_en        <= acc_en_s;
      out_valid     <= out_valid_s;
      busy          <= busy_s;
      overrun       <= overrun_s;
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: drives a default build and a 4-tap zero-latency
// build side by side. A timing model keyed on each sample's acceptance
// cycle predicts every output each cycle, and a scoreboard queue holds the
// expected first out_valid cycle of every accepted sample.

module tb_fir_tap_sequencer;

  logic clk;
  logic rst_n;

  // Default build (64 taps, latency 2)
  logic       sv0, ordy0, clr0;
  logic       sr0, p0_0, ac0, ae0, ov0, busy0, orun0;
  logic [5:0] cnt0;

  // Small build (4 taps, latency 0)
  logic       sv1, ordy1, clr1;
  logic       sr1, p0_1, ac1, ae1, ov1, busy1, orun1;
  logic [1:0] cnt1;

  int n_checks;
  int n_errors;
  int cyc;

  // Model state per build: in flight, acceptance cycle, sticky overrun
  bit act_m [2];
  int ta_m  [2];
  bit ov_m  [2];
  int nt_m  [2];
  int lat_m [2];
  bit prev_v[2];
  int q0[$];
  int q1[$];

  fir_tap_sequencer #(.NUM_TAPS(64), .CNT_W(6), .MAC_LATENCY(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sv0), .sample_ready(sr0),
    .phase_0(p0_0), .current_count(cnt0), .acc_clear(ac0), .acc_en(ae0),
    .out_valid(ov0), .out_ready(ordy0), .busy(busy0), .overrun(orun0),
    .clear_overrun(clr0)
  );

  fir_tap_sequencer #(.NUM_TAPS(4), .CNT_W(2), .MAC_LATENCY(0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .sample_valid(sv1), .sample_ready(sr1),
    .phase_0(p0_1), .current_count(cnt1), .acc_clear(ac1), .acc_en(ae1),
    .out_valid(ov1), .out_ready(ordy1), .busy(busy1), .overrun(orun1),
    .clear_overrun(clr1)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Packed view: {sample_ready, phase_0, busy, acc_en, acc_clear, out_valid, overrun, count[7:0]}
  function automatic logic [14:0] obs_vec(input int d);
    if (d == 0) return {sr0, p0_0, busy0, ae0, ac0, ov0, orun0, 8'(cnt0)};
    else        return {sr1, p0_1, busy1, ae1, ac1, ov1, orun1, 8'(cnt1)};
  endfunction

  // Expected outputs for the current cycle from the acceptance time alone
  function automatic logic [14:0] exp_vec(input int d);
    logic [14:0] v;
    int rel;
    int n;
    int l;
    n = nt_m[d];
    l = lat_m[d];
    v = 15'h0000;
    if (!act_m[d]) begin
      v[14] = 1'b1;
    end else begin
      rel   = cyc - ta_m[d];
      v[13] = (rel == 1);
      v[12] = 1'b1;
      v[11] = (rel >= 2) && (rel <= n + 1);
      v[10] = (rel == 2);
      v[9]  = (rel >= n + 2 + l);
      if ((rel >= 2) && (rel <= n + 1)) v[7:0] = 8'(rel - 2);
    end
    v[8] = ov_m[d];
    return v;
  endfunction

  // Advance the model with the inputs held during the current cycle
  task automatic update_model(input int d, input bit sv, input bit ordy, input bit clr);
    logic [14:0] e;
    bit set_ov;
    e = exp_vec(d);
    set_ov = sv && !e[14];
    if (act_m[d] && e[9] && ordy) begin
      act_m[d] = 1'b0;
    end else if (!act_m[d] && sv) begin
      act_m[d] = 1'b1;
      ta_m[d]  = cyc;
      if (d == 0) q0.push_back(cyc + nt_m[d] + lat_m[d] + 2);
      else        q1.push_back(cyc + nt_m[d] + lat_m[d] + 2);
    end
    if (set_ov)   ov_m[d] = 1'b1;
    else if (clr) ov_m[d] = 1'b0;
  endtask

  task automatic check_outputs();
    logic [14:0] o;
    int e;
    for (int d = 0; d < 2; d++) begin
      o = obs_vec(d);
      check_eq((d == 0) ? "outs_64" : "outs_4", 32'(o), 32'(exp_vec(d)));
      if (o[9] && !prev_v[d]) begin
        e = -1;
        if (d == 0) begin
          if (q0.size() > 0) e = q0.pop_front();
        end else begin
          if (q1.size() > 0) e = q1.pop_front();
        end
        check_eq((d == 0) ? "sb_valid_time_64" : "sb_valid_time_4", cyc, e);
      end
      prev_v[d] = o[9];
    end
  endtask

  task automatic tick();
    update_model(0, sv0, ordy0, clr0);
    update_model(1, sv1, ordy1, clr1);
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      act_m[d]  = 1'b0;
      ov_m[d]   = 1'b0;
      prev_v[d] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  initial begin
    int t0;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    nt_m[0] = 64; lat_m[0] = 2;
    nt_m[1] = 4;  lat_m[1] = 0;
    ta_m[0] = 0;  ta_m[1] = 0;
    model_reset();
    rst_n = 1'b0;
    sv0 = 1'b0; ordy0 = 1'b0; clr0 = 1'b0;
    sv1 = 1'b0; ordy1 = 1'b0; clr1 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_vals_64", 32'(obs_vec(0)), 32'h4000);
    check_eq("reset_vals_4", 32'(obs_vec(1)), 32'h4000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    check_outputs();

    // Idle after reset: ready high, everything else low
    repeat (100) tick();

    // Single sample, result taken immediately
    ordy0 = 1'b1;
    sv0 = 1'b1;
    tick();
    sv0 = 1'b0;
    repeat (75) tick();

    // Downstream stalls until T+80
    ordy0 = 1'b0;
    t0 = cyc;
    sv0 = 1'b1;
    tick();
    sv0 = 1'b0;
    while (cyc < t0 + 80) tick();
    ordy0 = 1'b1;
    tick();
    ordy0 = 1'b0;
    repeat (3) tick();

    // Overruns, clear, and clear coincident with a new overrun
    t0 = cyc;
    sv0 = 1'b1;
    tick();
    tick();
    sv0 = 1'b0;
    while (cyc < t0 + 40) tick();
    sv0 = 1'b1;
    tick();
    sv0 = 1'b0;
    while (cyc < t0 + 50) tick();
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    while (cyc < t0 + 60) tick();
    sv0 = 1'b1;
    clr0 = 1'b1;
    tick();
    sv0 = 1'b0;
    clr0 = 1'b0;
    ordy0 = 1'b1;
    repeat (15) tick();
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    tick();

    // Asynchronous reset in the middle of the sweep
    t0 = cyc;
    sv0 = 1'b1;
    tick();
    sv0 = 1'b0;
    while (cyc < t0 + 30) tick();
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_64", 32'(obs_vec(0)), 32'h4000);
    check_eq("rst_async_4", 32'(obs_vec(1)), 32'h4000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();
    sv0 = 1'b1;
    tick();
    sv0 = 1'b0;
    repeat (75) tick();

    // Small build: samples every 7 cycles must never overrun
    ordy1 = 1'b1;
    repeat (6) begin
      sv1 = 1'b1;
      tick();
      sv1 = 1'b0;
      repeat (6) tick();
    end
    repeat (5) tick();
    check_eq("no_overrun_4", 32'(orun1), 32'(ov_m[1]));

    check_eq("sb_left_64", q0.size(), 0);
    check_eq("sb_left_4", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Per-sample controller for one equalizer band's serial FIR datapath. It sequences the 64-slot sample delay line and the shared multiply-accumulate unit. For each accepted audio sample it pulses a shift strobe into the delay line, then sweeps the tap index across all slots while enabling the accumulator. It then waits for the MAC pipeline to drain and presents a result-valid handshake to the band output stage.

## Interface
Parameters:
- NUM_TAPS, 64, delay-line slots / coefficients per band; must be ≥ 2
- CNT_W, 6, tap-index width; ≥ clog2(NUM_TAPS)
- MAC_LATENCY, 2, register stages between `acc_en` and a settled accumulator; 0 allowed

Ports:
- clk  in  1  single system clock; all state changes on rising edge
- rst_n  in  1  reset; asynchronous and active-low
- sample_valid  in  1  new audio sample present on the band's filter input this cycle
- sample_ready  out  1  sequencer can accept a sample (IDLE only)
- phase_0  out  1  one-cycle shift strobe to the delay line
- current_count  out  CNT_W  tap index, which drives the delay-line mux and the coefficient address
- acc_clear  out  1  accumulator loads the product instead of adding it (first tap only)
- acc_en  out  1  accumulator update enable
- out_valid  out  1  accumulator holds the finished band result
- out_ready  in  1  downstream takes the result
- busy  out  1  high in every state except IDLE
- overrun  out  1  sticky: a sample arrived while not ready
- clear_overrun  in  1  synchronous clear of `overrun`

## Operation
- All outputs are registered. Reset value of every output is 0, except `sample_ready`, which is 1. The state resets to IDLE.
- States and transitions:
  - IDLE → SHIFT on `sample_valid && sample_ready`.
  - SHIFT → MAC unconditionally. SHIFT lasts 1 cycle with `phase_0 = 1`.
  - MAC → DRAIN after the cycle with `current_count == NUM_TAPS-1`. If MAC_LATENCY = 0, MAC → HOLD instead.
  - DRAIN → HOLD after MAC_LATENCY cycles.
  - HOLD → IDLE on `out_ready`.
- MAC behaviour: `current_count` steps 0,1,…,NUM_TAPS-1, one per cycle. `acc_en = 1` throughout MAC. `acc_clear = 1` only when count = 0.
- `current_count` is 0 in IDLE, SHIFT, DRAIN and HOLD. It never exceeds NUM_TAPS-1 and never wraps inside MAC.
- HOLD: `out_valid = 1` and stays high, with `acc_en = 0`, until `out_ready` is sampled high. The result is never dropped.
- Overrun: if `sample_valid = 1` while `sample_ready = 0`, the sample is ignored (no `phase_0`) and `overrun` is set next cycle.
  - `clear_overrun` clears `overrun`.
  - If a new overrun and `clear_overrun` occur in the same cycle, set wins.
- Reset mid-operation (any state) returns to IDLE immediately and clears all strobes. A partially accumulated result is discarded. The delay line is reset by its own reset.

## Timing
- A sample is accepted at the edge ending cycle T.
  - T+1: `phase_0 = 1`.
  - T+2 … T+1+NUM_TAPS: MAC sweep.
  - T+2+NUM_TAPS … T+1+NUM_TAPS+MAC_LATENCY: DRAIN.
  - `out_valid` first high at T+2+NUM_TAPS+MAC_LATENCY. With defaults this is T+68.
- Tap 0 is read in T+2, after the shift edge, so slot 0 holds the sample accepted at T.
- If `out_ready = 1` in the first `out_valid` cycle, the block is in IDLE the next cycle. `sample_ready` rises at T+3+NUM_TAPS+MAC_LATENCY, so the minimum sample period is NUM_TAPS+MAC_LATENCY+3 = 69 cycles.
- `sample_ready` and `out_valid` are never high in the same cycle.
- `sample_ready` falls in the cycle after acceptance. A back-to-back `sample_valid` in T+1 is therefore an overrun.

## Test plan
- Reset release, no stimulus → `sample_ready = 1` and all other outputs 0 for 100 cycles. `current_count` stays 0.
- Single sample at T, `out_ready` held 1 → `phase_0` only at T+1. Count 0..63 over T+2..T+65, with `acc_clear` only at T+2. `out_valid` for exactly one cycle at T+68. `sample_ready = 1` at T+69.
- Same stimulus but `out_ready = 0` until T+80 → `out_valid` high T+68..T+80, `acc_en = 0` throughout. IDLE at T+81.
- `sample_valid` at T+1 and T+40 → exactly one `phase_0`. `overrun = 1` from T+2. `clear_overrun` at T+50 → 0 at T+51. `clear_overrun` coincident with a new overrun → `overrun` stays 1.
- `rst_n` low at T+30 mid-sweep → same cycle (asynchronous): `acc_en`, `busy` and `current_count` are 0 and `sample_ready = 1`. After release, a new sample runs a full 64-tap sweep starting from count 0.
- MAC_LATENCY = 0, NUM_TAPS = 4 build → `out_valid` at T+6. Back-to-back samples every 7 cycles produce no overrun.
